// File: rtl/fifo_drain_packer.sv
// Drains a 1-cycle-latency FIFO and packs PACK_RATIO words per beat onto a valid/ready stream.
// Optional partial-beat flush on idle timeout is enabled by defining PACK_TIMEOUT_EN.
module fifo_drain_packer #(
  parameter int FIFO_WIDTH     = 16,
  parameter int PACK_RATIO     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0]            fifo_dout,
  input  logic                             fifo_empty,
  input  logic                             fifo_underflow,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [FIFO_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep,
  output logic [15:0]                      beat_count,
  output logic                             err_underflow
);

  localparam int CNT_W = $clog2(PACK_RATIO + 1);
  localparam int IDX_W = $clog2(PACK_RATIO);

  typedef enum logic [1:0] {FILL, HOLD, EMIT} state_t;

  if (PACK_RATIO < 2 || PACK_RATIO > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("fifo_drain_packer: PACK_RATIO must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  state_t                state;
  logic [CNT_W-1:0]      acc_cnt;
  logic                  inflight;
  logic [FIFO_WIDTH-1:0] lanes [PACK_RATIO];
  logic [CNT_W:0]        credit;
  logic                  out_free;
  logic                  xfer;
  logic                  flush;
  logic [PACK_RATIO-1:0] keep_mask;

  // A read is only issued when a lane is reserved for it, so backpressure never drops a word.
  assign credit     = {1'b0, acc_cnt} + {{CNT_W{1'b0}}, inflight};
  assign fifo_rd_en = rst_n && !fifo_empty && (credit < (CNT_W+1)'(PACK_RATIO));
  assign out_free   = !out_valid || out_ready;
  assign xfer       = (state == HOLD) && out_free;

`ifdef PACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  assign flush = (state == FILL) && (acc_cnt != '0) && !inflight && out_free &&
                 (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (inflight || flush) begin
      tmo_cnt <= '0;
    end else if ((state == FILL) && (acc_cnt != '0) && fifo_empty &&
                 (tmo_cnt != TMO_W'(TIMEOUT_CYCLES))) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Filled lanes are the low acc_cnt lanes; a full beat yields all ones.
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      keep_mask[i] = (CNT_W'(i) < acc_cnt);
    end
  end
`else
  assign flush     = 1'b0;
  assign keep_mask = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      acc_cnt       <= '0;
      inflight      <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_keep      <= '0;
      beat_count    <= '0;
      err_underflow <= 1'b0;
      for (int i = 0; i < PACK_RATIO; i++) lanes[i] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (fifo_underflow) err_underflow <= 1'b1;
      if (out_valid && out_ready) beat_count <= beat_count + 16'd1;

      // Transfer stage: no word can be in flight here, the credit rule blocked it.
      if (xfer || flush) begin
        out_valid <= 1'b1;
        out_keep  <= keep_mask;
        for (int i = 0; i < PACK_RATIO; i++) begin
          out_data[i*FIFO_WIDTH +: FIFO_WIDTH] <= lanes[i];
          lanes[i] <= '0;
        end
        acc_cnt <= '0;
        state   <= EMIT;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        if (inflight) begin
          lanes[acc_cnt[IDX_W-1:0]] <= fifo_dout;
          acc_cnt <= acc_cnt + 1'b1;
        end
        if (inflight && (acc_cnt == CNT_W'(PACK_RATIO - 1))) begin
          state <= HOLD;
        end else if (state == EMIT) begin
          state <= FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed bench for fifo_drain_packer with a small 1-cycle-latency FIFO model in front of it.
module tb_fifo_drain_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_rd_en;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_keep;
  logic [15:0] beat_count;
  logic        err_underflow;

  int n_pass = 0;
  int n_checks = 0;
  int rd_seen;

  logic [15:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always #5 clk = ~clk;

  fifo_drain_packer #(.FIFO_WIDTH(16), .PACK_RATIO(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .beat_count(beat_count), .err_underflow(err_underflow)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [15:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_beat(input string tag, input logic [63:0] d, input logic [3:0] k);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, {63'd0, out_valid}, 64'd1);
    if (out_valid) begin
      check({tag, "_data"}, out_data, d);
      check({tag, "_keep"}, {60'd0, out_keep}, {60'd0, k});
    end
    @(negedge clk);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_ready      = 1'b0;
    fifo_underflow = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data",  out_data, 64'd0);
    check("rst_keep",  {60'd0, out_keep}, 64'd0);
    check("rst_bcnt",  {48'd0, beat_count}, 64'd0);
    check("rst_err",   {63'd0, err_underflow}, 64'd0);
    rst_n = 1'b1;

    rd_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (fifo_rd_en) rd_seen++;
    end
    check("empty_rd_en", 64'(rd_seen), 64'd0);
    check("empty_valid", {63'd0, out_valid}, 64'd0);
    check("empty_err",   {63'd0, err_underflow}, 64'd0);

    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(16'(i));
    wait_beat("b1", 64'h0004_0003_0002_0001, 4'hF);
    wait_beat("b2", 64'h0008_0007_0006_0005, 4'hF);
    repeat (3) @(negedge clk);
    check("bcnt2",      {48'd0, beat_count}, 64'd2);
    check("idle_valid", {63'd0, out_valid}, 64'd0);

    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push(16'h0100 + 16'(i));
    repeat (20) @(negedge clk);
    check("hold_valid", {63'd0, out_valid}, 64'd1);
    check("hold_data",  out_data, 64'h0104_0103_0102_0101);
    check("hold_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("hold_level", 64'(wr_ptr - rd_ptr), 64'd4);
    repeat (5) @(negedge clk);
    check("hold_stable", out_data, 64'h0104_0103_0102_0101);
    check("hold_keep",   {60'd0, out_keep}, 64'hF);
    out_ready = 1'b1;
    wait_beat("d1", 64'h0104_0103_0102_0101, 4'hF);
    wait_beat("d2", 64'h0108_0107_0106_0105, 4'hF);
    wait_beat("d3", 64'h010C_010B_010A_0109, 4'hF);
    repeat (3) @(negedge clk);
    check("bcnt5",       {48'd0, beat_count}, 64'd5);
    check("drain_level", 64'(wr_ptr - rd_ptr), 64'd0);

    push(16'h0011);
    push(16'h0012);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("mid_valid", {63'd0, out_valid}, 64'd0);
    check("mid_data",  out_data, 64'd0);
    check("mid_keep",  {60'd0, out_keep}, 64'd0);
    check("mid_bcnt",  {48'd0, beat_count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) push(16'h0020 + 16'(i));
    wait_beat("clean", 64'h0024_0023_0022_0021, 4'hF);
    repeat (2) @(negedge clk);
    check("bcnt1", {48'd0, beat_count}, 64'd1);

    push(16'h000A);
    push(16'h000B);
    push(16'h000C);
`ifdef PACK_TIMEOUT_EN
    wait_beat("tmo", 64'h0000_000C_000B_000A, 4'b0111);
    repeat (2) @(negedge clk);
    check("tmo_bcnt", {48'd0, beat_count}, 64'd2);
`else
    repeat (40) @(negedge clk);
    check("no_partial", {63'd0, out_valid}, 64'd0);
    check("no_partial_bcnt", {48'd0, beat_count}, 64'd1);
`endif

    fifo_underflow = 1'b1;
    @(negedge clk);
    fifo_underflow = 1'b0;
    check("uflow_set", {63'd0, err_underflow}, 64'd1);
    repeat (4) @(negedge clk);
    check("uflow_sticky", {63'd0, err_underflow}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("uflow_clr", {63'd0, err_underflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
